// File: rtl/dotmatrix_track_decoder.sv
// Receive-side monitor for a 4x4 one-hot dot-matrix bus: glitch-filters the
// lines, recovers the dot position and classifies moves between frames.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_OFF   | powered down or just reset; everything cleared
// ST_ACQ   | filtering, no position held yet
// ST_TRACK | position held; each new one-hot frame is a step or a jump
// ST_FAULT | last accepted frame was not one-hot; position frozen
module dotmatrix_track_decoder #(
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             power,
  input  logic [15:0]      y,
  output logic             pos_valid,
  output logic [1:0]       row,
  output logic [1:0]       col,
  output logic             move,
  output logic             dir_up,
  output logic             dir_down,
  output logic             dir_right,
  output logic             dir_left,
  output logic             jump,
  output logic             fault,
  output logic             fault_zero,
  output logic [CNT_W-1:0] move_count
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_ACQ   = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [1:0]  state;
  logic [15:0] y_q;
  logic [15:0] cand;
  logic [3:0]  stab_cnt;

  logic        same;
  logic [3:0]  cnt_next;
  logic        accept;
  logic        onehot;
  logic [1:0]  new_row;
  logic [1:0]  new_col;
  logic [1:0]  dr;
  logic [1:0]  dc;

  // A pattern is accepted only on the edge its run first reaches STABLE;
  // a fresh pattern with STABLE=1 is accepted even if the counter sits at 1.
  always_comb begin
    same     = (y_q == cand);
    cnt_next = 4'd1;
    if (same) begin
      cnt_next = (stab_cnt == STABLE) ? STABLE : stab_cnt + 4'd1;
    end
    accept = (cnt_next == STABLE) && (!same || (stab_cnt != STABLE));
    onehot = $onehot(y_q);
  end

  always_comb begin
    new_row = 2'd0;
    new_col = 2'd0;
    for (int i = 0; i < 16; i++) begin
      if (y_q[i]) begin
        new_row = i[3:2];
        new_col = i[1:0];
      end
    end
    dr = new_row - row;
    dc = new_col - col;
  end

  always_ff @(posedge clk) begin
    if (reset || !power) begin
      state      <= ST_OFF;
      y_q        <= '0;
      cand       <= '0;
      stab_cnt   <= '0;
      pos_valid  <= 1'b0;
      row        <= '0;
      col        <= '0;
      move       <= 1'b0;
      dir_up     <= 1'b0;
      dir_down   <= 1'b0;
      dir_right  <= 1'b0;
      dir_left   <= 1'b0;
      jump       <= 1'b0;
      fault      <= 1'b0;
      fault_zero <= 1'b0;
      move_count <= '0;
    end else begin
      y_q      <= y;
      stab_cnt <= cnt_next;
      if (!same) begin
        cand <= y_q;
      end
      move <= 1'b0;
      jump <= 1'b0;
      if (state == ST_OFF) begin
        state <= ST_ACQ;
      end
      if (accept) begin
        if (!onehot) begin
          state      <= ST_FAULT;
          fault      <= 1'b1;
          fault_zero <= (y_q == 16'd0);
          pos_valid  <= 1'b0;
        end else if (state == ST_TRACK) begin
          row <= new_row;
          col <= new_col;
          if ((dr == 2'd2) || (dc == 2'd2)) begin
            jump <= 1'b1;
          end else if ((dr != 2'd0) || (dc != 2'd0)) begin
            move      <= 1'b1;
            dir_down  <= (dr == 2'd1);
            dir_up    <= (dr == 2'd3);
            dir_right <= (dc == 2'd1);
            dir_left  <= (dc == 2'd3);
            if (move_count != {CNT_W{1'b1}}) begin
              move_count <= move_count + 1'b1;
            end
          end
        end else begin
          // OFF/ACQ/FAULT: a clean dot (re)establishes position silently
          state      <= ST_TRACK;
          row        <= new_row;
          col        <= new_col;
          pos_valid  <= 1'b1;
          fault      <= 1'b0;
          fault_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/dotmatrix_track_decoder.md
Name: dotmatrix_track_decoder

Overview:
- Receive-side monitor for the 4x4 dot-matrix display bus.
- Samples the 16 display lines driven by the dot-matrix controller and checks that exactly one dot is lit.
- Recovers the dot's row/column and infers the move direction (up/down/right/left, including diagonals and wrap-around) between accepted frames.
- Used as a self-checking receiver in system benches and as a position-readback source for higher-level game logic.

Parameters:
- STABLE_CYCLES, 2, consecutive identical samples required before a pattern is accepted (glitch filter); legal range 1..15.
- CNT_W, 8, width of the saturating move counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- power  input  1  block enable; 0 forces the block to OFF.
- y  input  16  display lines; bit index 4*row+col (y[0]=y00, y[5]=y11, y[15]=y33); row 0 = top, col 0 = left.
- pos_valid  output  1  a valid position is held.
- row  output  2  accepted dot row.
- col  output  2  accepted dot column.
- move  output  1  one-cycle pulse on an accepted position change.
- dir_up, dir_down, dir_right, dir_left  output  1 each  direction of the last move; held until the next move.
- jump  output  1  one-cycle pulse when a position change is not a single-step move.
- fault  output  1  level; the current accepted pattern is not one-hot.
- fault_zero  output  1  qualifies fault: 1 = no dot lit, 0 = multiple dots lit.
- move_count  output  CNT_W  number of valid moves, saturating at all-ones.

Behaviour:
- Reset (reset=1 at an edge), and every cycle with power=0:
  - All outputs are 0 and the state is OFF.
  - The internal sample register, candidate register and stability counter are cleared.
- Reset has priority over power. Reset mid-operation discards any partially filtered pattern.
- Input filter:
  - y is registered into y_q every cycle.
  - If y_q equals the candidate, the stability counter increments, saturating at STABLE_CYCLES. Otherwise candidate<=y_q and the counter is set to 1.
  - A pattern is accepted on the edge where the counter first reaches STABLE_CYCLES.
  - Latency: outputs update on the STABLE_CYCLES-th edge after the new pattern reaches y_q, i.e. STABLE_CYCLES+1 edges after it appears on y.
  - A pattern that changes before acceptance is ignored entirely.
- States:
  - OFF: power=1 moves the block to ACQUIRE.
  - ACQUIRE: no position held.
    - Accepted one-hot: load row/col, pos_valid=1, go to TRACK. No move pulse.
    - Accepted non-one-hot: go to FAULT.
  - TRACK: on each accepted one-hot pattern, compute dr=(new_row-row) mod 4 and dc=(new_col-col) mod 4.
    - dr and dc both in {0,1,3}, not both 0: valid step.
      - move=1 for one cycle; move_count increments.
      - dir_down=(dr==1), dir_up=(dr==3), dir_right=(dc==1), dir_left=(dc==3); a diagonal sets two bits.
      - Wrap-around counts as a single step, e.g. col 3->0 is right.
    - Either delta ==2: jump=1 for one cycle. row/col update, dir bits and count unchanged, move stays 0.
    - Same position re-accepted (dr=dc=0): no pulses. This cannot occur without an intervening pattern change.
    - Accepted non-one-hot: go to FAULT.
  - FAULT: fault=1, pos_valid=0, fault_zero set per the pattern; row/col hold their last values.
    - Accepted one-hot: clear fault, load position, pos_valid=1, go to TRACK. No move pulse, no jump.
- move and jump are never both 1. Pulses last exactly one cycle.
- move_count wraps never; it holds at 2^CNT_W-1.
- power deasserting mid-filter aborts the pending pattern.

Test Plan:
1. reset=1 for 2 edges, power=1, y=0x0001 held -> pos_valid rises 3 edges after y is applied (STABLE_CYCLES=2) with row=0, col=0, move=0, move_count=0.
2. From (0,0), y=0x0010 -> move pulses once; dir_down=1, others 0; row=1, col=0; move_count=1. Then y=0x0020 -> dir_right only; row=1, col=1; move_count=2.
3. Wrap and diagonal:
   - From (1,1), y=0x0004 -> (0,2), dir_up=1 and dir_right=1.
   - Then y=0x0008 (col 3) followed by y=0x0001 -> the second move reports dir_right=1 via wrap.
4. Glitch and jump:
   - From (0,0), y=0x0010 held only 1 cycle, then back to 0x0001 -> no move, count unchanged.
   - Then y=0x0400 (2,2) -> jump=1, move=0, row=2, col=2.
5. Faults:
   - y=0x0000 stable -> fault=1, fault_zero=1, pos_valid=0.
   - y=0x0011 -> fault_zero=0.
   - y=0x8000 -> fault=0, pos_valid=1, row=3, col=3, no move pulse.
6. Control:
   - power=0 mid-track -> all outputs 0 on the next edge; power=1 -> reacquire without a move.
   - reset=1 while power=1 -> outputs cleared.
   - With CNT_W=2, 5 valid moves -> move_count=3.
